// File: rtl/bpu_gshare_pkg.sv
// Shared types and constants for the gshare branch predictor.
// BTB entry field widths follow the default 32-bit pc / 64-entry BTB geometry.
package bpu_pkg;

    localparam int BPU_ADDR_W = 32;
    localparam int BPU_TAG_W  = 24;

    typedef enum logic [1:0] {
        COND = 2'd0,
        CALL = 2'd1,
        RET  = 2'd2
    } br_type_e;

    typedef struct packed {
        logic                  valid;
        logic [BPU_TAG_W-1:0]  tag;
        br_type_e              btype;
        logic [BPU_ADDR_W-1:0] target;
    } btb_entry_t;

    localparam logic [1:0] PHT_INIT   = 2'b01;
    localparam int         INST_BYTES = 4;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != 2'b00)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/bpu_gshare_if.sv
// Fetch-side lookup and execute-side resolution signals of the branch predictor.
interface bpu_gshare_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
    logic                  pred_hit;
    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic [ADDR_WIDTH-1:0] upd_target;
    logic                  upd_taken;
    logic                  upd_is_call;
    logic                  upd_is_ret;

    modport master (
        output pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_call, upd_is_ret,
        input  pred_taken, pred_target, pred_hit
    );

    modport slave (
        input  pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_call, upd_is_ret,
        output pred_taken, pred_target, pred_hit
    );
endinterface

// File: rtl/bpu_gshare_ras.sv
// Circular return address stack; a push when full drops the oldest entry,
// a pop when empty is ignored.
module bpu_ras #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] ptr_prev;
    logic [CNT_W-1:0] count;

    // ptr is the next free slot; the top of stack sits just below it.
    assign ptr_next = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    assign ptr_prev = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - PTR_W'(1);
    assign top      = mem[ptr_prev];
    assign empty    = (count == '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr_next;
            if (count != CNT_W'(DEPTH))
                count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr_prev;
            count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/bpu_gshare.sv
// Gshare direction predictor with a typed, tagged BTB and a return address stack.
// Lookup is purely combinational; training happens on resolved branches only.
module bpu_gshare
    import bpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int PHT_WIDTH  = 6,
    parameter int GHR_WIDTH  = 6,
    parameter int BTB_WIDTH  = 6,
    parameter int RAS_DEPTH  = 4
) (
    input  logic     clk,
    input  logic     rst,
    bpu_gshare_if.slave bus
);
    localparam int PHT_N = 1 << PHT_WIDTH;
    localparam int BTB_N = 1 << BTB_WIDTH;

    logic [GHR_WIDTH-1:0] ghr;
    logic [1:0]           pht [PHT_N];
    btb_entry_t           btb [BTB_N];

    logic [ADDR_WIDTH-1:0] ras_top;
    logic                  ras_empty;

    logic [PHT_WIDTH-1:0]  lk_pht_idx;
    logic [BTB_WIDTH-1:0]  lk_btb_idx;
    btb_entry_t            lk_entry;
    logic                  lk_hit;
    logic                  lk_taken;
    logic [ADDR_WIDTH-1:0] lk_target;

    assign lk_pht_idx = bus.pc[PHT_WIDTH+1:2] ^ PHT_WIDTH'(ghr);
    assign lk_btb_idx = bus.pc[BTB_WIDTH+1:2];
    assign lk_entry   = btb[lk_btb_idx];
    assign lk_hit     = lk_entry.valid &&
                        (lk_entry.tag == BPU_TAG_W'(bus.pc[ADDR_WIDTH-1:BTB_WIDTH+2]));

    always_comb begin
        lk_taken  = 1'b0;
        lk_target = ADDR_WIDTH'(lk_entry.target);
        case (lk_entry.btype)
            COND:    lk_taken = lk_hit & pht[lk_pht_idx][1];
            CALL:    lk_taken = lk_hit;
            RET: begin
                lk_taken = lk_hit;
                if (!ras_empty)
                    lk_target = ras_top;
            end
            default: lk_taken = 1'b0;
        endcase
    end

    assign bus.pred_hit    = lk_hit;
    assign bus.pred_taken  = lk_taken;
    assign bus.pred_target = lk_taken ? lk_target : bus.pc + ADDR_WIDTH'(INST_BYTES);

    logic                 upd_cond;
    logic [PHT_WIDTH-1:0] upd_pht_idx;
    logic [BTB_WIDTH-1:0] upd_btb_idx;
    logic                 pht_we;
    logic [1:0]           pht_next;
    logic                 btb_we;
    btb_entry_t           btb_wdata;

    assign upd_cond    = !bus.upd_is_call && !bus.upd_is_ret;
    assign upd_pht_idx = bus.upd_pc[PHT_WIDTH+1:2] ^ PHT_WIDTH'(ghr);
    assign upd_btb_idx = bus.upd_pc[BTB_WIDTH+1:2];
    assign pht_we      = bus.upd_valid && upd_cond;
    assign pht_next    = sat_update(pht[upd_pht_idx], bus.upd_taken);
    assign btb_we      = bus.upd_valid && (bus.upd_taken || bus.upd_is_call || bus.upd_is_ret);

    // A call that is also flagged as a return is stored and handled as a return.
    always_comb begin
        btb_wdata.valid  = 1'b1;
        btb_wdata.tag    = BPU_TAG_W'(bus.upd_pc[ADDR_WIDTH-1:BTB_WIDTH+2]);
        btb_wdata.btype  = bus.upd_is_ret ? RET : (bus.upd_is_call ? CALL : COND);
        btb_wdata.target = BPU_ADDR_W'(bus.upd_target);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ghr <= '0;
        else if (pht_we)
            ghr <= {ghr[GHR_WIDTH-2:0], bus.upd_taken};
    end

    for (genvar i = 0; i < PHT_N; i++) begin : g_pht
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                pht[i] <= PHT_INIT;
            else if (pht_we && upd_pht_idx == PHT_WIDTH'(i))
                pht[i] <= pht_next;
        end
    end

    for (genvar i = 0; i < BTB_N; i++) begin : g_btb
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                btb[i] <= '0;
            else if (btb_we && upd_btb_idx == BTB_WIDTH'(i))
                btb[i] <= btb_wdata;
        end
    end

    bpu_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.upd_valid && bus.upd_is_call && !bus.upd_is_ret),
        .pop       (bus.upd_valid && bus.upd_is_ret),
        .push_data (bus.upd_pc + ADDR_WIDTH'(INST_BYTES)),
        .top       (ras_top),
        .empty     (ras_empty)
    );
endmodule

// File: tb/tb_bpu_gshare.sv
// Scoreboard bench for bpu_gshare: expected predictions are queued with each lookup
// and compared against the sampled outputs at the end of every scenario.
module tb_bpu_gshare;

    typedef struct packed {
        logic        taken;
        logic        hit;
        logic [31:0] target;
    } pred_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bpu_gshare_if #(.ADDR_WIDTH(32)) bus ();

    bpu_gshare #(
        .ADDR_WIDTH (32),
        .PHT_WIDTH  (6),
        .GHR_WIDTH  (6),
        .BTB_WIDTH  (6),
        .RAS_DEPTH  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pred_t exp_q [$];
    pred_t obs_q [$];
    string name_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic idle_upd();
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = '0;
        bus.upd_target  = '0;
        bus.upd_taken   = 1'b0;
        bus.upd_is_call = 1'b0;
        bus.upd_is_ret  = 1'b0;
    endtask

    task automatic upd(input logic [31:0] p, input logic [31:0] t,
                       input logic tk, input logic call, input logic ret);
        @(negedge clk);
        bus.upd_valid   = 1'b1;
        bus.upd_pc      = p;
        bus.upd_target  = t;
        bus.upd_taken   = tk;
        bus.upd_is_call = call;
        bus.upd_is_ret  = ret;
        @(negedge clk);
        idle_upd();
    endtask

    task automatic look(input logic [31:0] p, input logic tk, input logic hit,
                        input logic [31:0] tgt, input string nm);
        bus.pc = p;
        exp_q.push_back('{taken: tk, hit: hit, target: tgt});
        name_q.push_back(nm);
        #1;
        obs_q.push_back('{taken: bus.pred_taken, hit: bus.pred_hit, target: bus.pred_target});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        pred_t e, o;
        string nm;
        look(32'h1C00_0000, 1'b0, 1'b0, 32'h1C00_0004, "reset_held");
        #2;
        rst = 1'b1;
        look(32'h1C00_0000, 1'b0, 1'b0, 32'h1C00_0004, "reset_released");
        @(negedge clk);
        look(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, "pc_wrap");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got taken=%b hit=%b target=%h, want taken=%b hit=%b target=%h",
                         nm, o.taken, o.hit, o.target, e.taken, e.hit, e.target);
            end
        end
    endtask

    task automatic test_cond_train();
        pred_t e, o;
        string nm;
        do_reset();
        for (int i = 0; i < 8; i++)
            upd(32'h1C00_0010, 32'h1C00_0100, 1'b1, 1'b0, 1'b0);
        look(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0100, "cond_trained");
        look(32'h1C00_0014, 1'b0, 1'b0, 32'h1C00_0018, "cond_neighbour_miss");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got taken=%b hit=%b target=%h, want taken=%b hit=%b target=%h",
                         nm, o.taken, o.hit, o.target, e.taken, e.hit, e.target);
            end
        end
    endtask

    // Continues from test_cond_train: GHR=0x3F, counter at index 0x3B is 11.
    // The six-update rebuild from GHR=0x3E never touches index 0x3B.
    task automatic test_hysteresis();
        pred_t e, o;
        string nm;
        upd(32'h1C00_0010, 32'h1C00_0100, 1'b1, 1'b0, 1'b0);
        look(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0100, "sat_hold_11");
        upd(32'h1C00_0010, 32'h1C00_0100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            upd(32'h1C00_0010, 32'h1C00_0100, 1'b1, 1'b0, 1'b0);
        look(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0100, "weak_taken_10");
        upd(32'h1C00_0010, 32'h1C00_0100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            upd(32'h1C00_0010, 32'h1C00_0100, 1'b1, 1'b0, 1'b0);
        look(32'h1C00_0010, 1'b0, 1'b1, 32'h1C00_0014, "weak_not_taken_01");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got taken=%b hit=%b target=%h, want taken=%b hit=%b target=%h",
                         nm, o.taken, o.hit, o.target, e.taken, e.hit, e.target);
            end
        end
    endtask

    task automatic test_call_ret();
        pred_t e, o;
        string nm;
        do_reset();
        upd(32'h1C00_0020, 32'h1C00_0200, 1'b1, 1'b1, 1'b0);
        upd(32'h1C00_0300, 32'h1C00_0024, 1'b1, 1'b0, 1'b1);
        upd(32'h1C00_0040, 32'h1C00_0400, 1'b1, 1'b1, 1'b0);
        look(32'h1C00_0300, 1'b1, 1'b1, 32'h1C00_0044, "ret_uses_ras");
        look(32'h1C00_0020, 1'b1, 1'b1, 32'h1C00_0200, "call_uses_btb");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got taken=%b hit=%b target=%h, want taken=%b hit=%b target=%h",
                         nm, o.taken, o.hit, o.target, e.taken, e.hit, e.target);
            end
        end
    endtask

    task automatic test_ras_wrap();
        pred_t e, o;
        string nm;
        logic [31:0] ret_exp [5];
        ret_exp = '{32'h0000_0404, 32'h0000_0304, 32'h0000_0204, 32'hDEAD_0000, 32'hDEAD_0000};
        do_reset();
        upd(32'h1C00_0608, 32'hDEAD_0000, 1'b1, 1'b0, 1'b1);
        look(32'h1C00_0608, 1'b1, 1'b1, 32'hDEAD_0000, "ret_empty_ras");
        for (int i = 1; i <= 5; i++)
            upd(32'h100 * i, 32'h1000 * i, 1'b1, 1'b1, 1'b0);
        look(32'h1C00_0608, 1'b1, 1'b1, 32'h0000_0504, "ras_full_top");
        for (int i = 0; i < 5; i++) begin
            upd(32'h1C00_0608, 32'hDEAD_0000, 1'b1, 1'b0, 1'b1);
            look(32'h1C00_0608, 1'b1, 1'b1, ret_exp[i], $sformatf("ras_pop_%0d", i + 1));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got taken=%b hit=%b target=%h, want taken=%b hit=%b target=%h",
                         nm, o.taken, o.hit, o.target, e.taken, e.hit, e.target);
            end
        end
    endtask

    task automatic test_btb_rules();
        pred_t e, o;
        string nm;
        do_reset();
        upd(32'h1C00_00A0, 32'h1C00_0B00, 1'b1, 1'b1, 1'b1);
        look(32'h1C00_00A0, 1'b1, 1'b1, 32'h1C00_0B00, "call_and_ret_no_push");
        upd(32'h1C00_0080, 32'h1C00_0800, 1'b0, 1'b0, 1'b0);
        look(32'h1C00_0080, 1'b0, 1'b0, 32'h1C00_0084, "nt_miss_no_alloc");
        upd(32'h1C00_0090, 32'h1C00_0900, 1'b1, 1'b1, 1'b0);
        upd(32'h1D00_0090, 32'h1D00_0A00, 1'b1, 1'b1, 1'b0);
        look(32'h1C00_0090, 1'b0, 1'b0, 32'h1C00_0094, "conflict_evicted");
        look(32'h1D00_0090, 1'b1, 1'b1, 32'h1D00_0A00, "conflict_new");
        @(negedge clk);
        bus.upd_pc      = 32'h1C00_00C0;
        bus.upd_target  = 32'h1C00_0C00;
        bus.upd_taken   = 1'b1;
        bus.upd_is_call = 1'b1;
        @(negedge clk);
        idle_upd();
        look(32'h1C00_00C0, 1'b0, 1'b0, 32'h1C00_00C4, "valid_low_ignored");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got taken=%b hit=%b target=%h, want taken=%b hit=%b target=%h",
                         nm, o.taken, o.hit, o.target, e.taken, e.hit, e.target);
            end
        end
    endtask

    task automatic test_same_cycle();
        pred_t e, o;
        string nm;
        do_reset();
        @(negedge clk);
        bus.upd_valid   = 1'b1;
        bus.upd_pc      = 32'h1C00_00D0;
        bus.upd_target  = 32'h1C00_0D00;
        bus.upd_taken   = 1'b1;
        bus.upd_is_call = 1'b1;
        look(32'h1C00_00D0, 1'b0, 1'b0, 32'h1C00_00D4, "same_cycle_pre_update");
        @(negedge clk);
        idle_upd();
        look(32'h1C00_00D0, 1'b1, 1'b1, 32'h1C00_0D00, "same_cycle_post_update");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got taken=%b hit=%b target=%h, want taken=%b hit=%b target=%h",
                         nm, o.taken, o.hit, o.target, e.taken, e.hit, e.target);
            end
        end
    endtask

    task automatic test_async_reset();
        pred_t e, o;
        string nm;
        do_reset();
        upd(32'h1C00_00E0, 32'h1C00_0E00, 1'b1, 1'b1, 1'b0);
        look(32'h1C00_00E0, 1'b1, 1'b1, 32'h1C00_0E00, "trained_before_reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        look(32'h1C00_00E0, 1'b0, 1'b0, 32'h1C00_00E4, "async_reset_no_edge");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        look(32'h1C00_00E0, 1'b0, 1'b0, 32'h1C00_00E4, "after_reset_release");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got taken=%b hit=%b target=%h, want taken=%b hit=%b target=%h",
                         nm, o.taken, o.hit, o.target, e.taken, e.hit, e.target);
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        bus.pc = '0;
        idle_upd();
        test_reset();
        test_cond_train();
        test_hysteresis();
        test_call_ret();
        test_ras_wrap();
        test_btb_rules();
        test_same_cycle();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
